// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one vector RAM between the host bus and the executor.
// Each requester has its own auto-incrementing 24-bit pointer; accesses run IDLE -> SETUP -> STROBE -> HOLD.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin tie-break; default is fixed priority with exe winning ties).
module ram_access_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 8,
    parameter int RAM_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_ld,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              exe_ld,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic              exe_req,
    output logic              exe_ack,
    output logic [DATA_W-1:0] exe_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;
    localparam int CW = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              owner;
    logic              wr;
    logic              grant;
    logic              exe_win;
    logic              strobe_end;
    logic              done;
    logic [ADDR_W-1:0] host_ptr;
    logic [ADDR_W-1:0] exe_ptr;

    assign grant      = (state == IDLE) && (host_req || exe_req);
    assign strobe_end = (state == STROBE) && (cnt == CW'(RAM_WAIT - 1));
    assign done       = (state == HOLD);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_exe;
    assign exe_win = exe_req && (!host_req || !last_exe);
    // Remember who was served last so the other side wins the next tie
    always_ff @(posedge clk) begin
        if (reset)
            last_exe <= 1'b0;
        else if (grant)
            last_exe <= exe_win;
    end
`else
    assign exe_win = exe_req;
`endif

    // Access sequencer; owner is 1 for the executor, which only ever reads
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state <= SETUP;
                    owner <= exe_win;
                    wr    <= !exe_win && host_we;
                end
                SETUP: begin
                    state <= STROBE;
                    cnt   <= '0;
                end
                STROBE: begin
                    state <= strobe_end ? HOLD : STROBE;
                    cnt   <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM bus registers: address taken from the owner's pointer at the end of SETUP, write data at grant
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if (state == SETUP)
                ram_addr <= owner ? exe_ptr : host_ptr;
            if (grant && !exe_win && host_we)
                ram_wdata <= host_wdata;
        end
    end

    // Pointers: a preload overrides the post-increment of an access finishing in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            host_ptr <= '0;
            exe_ptr  <= '0;
        end else begin
            host_ptr <= host_ld ? host_addr : (done && !owner) ? host_ptr + ADDR_W'(1) : host_ptr;
            exe_ptr  <= exe_ld ? exe_addr : (done && owner) ? exe_ptr + ADDR_W'(1) : exe_ptr;
        end
    end

    // Read data captured on the last strobe cycle; ack pulses as HOLD ends
    always_ff @(posedge clk) begin
        if (reset) begin
            host_ack   <= 1'b0;
            exe_ack    <= 1'b0;
            host_rdata <= '0;
            exe_rdata  <= '0;
        end else begin
            host_ack <= done && !owner;
            exe_ack  <= done && owner;
            if (strobe_end && !wr && !owner)
                host_rdata <= ram_rdata;
            if (strobe_end && owner)
                exe_rdata <= ram_rdata;
        end
    end

    assign ram_cs = (state != IDLE);
    assign ram_oe = (state == STROBE) && !wr;
    assign ram_we = (state == STROBE) && wr;
    assign busy   = ram_cs;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and randomized checks of ram_access_arbiter against a transaction-level model.
module tb_ram_access_arbiter;
    localparam int AW = 24;
    localparam int DW = 8;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_ld = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic          exe_ld = 1'b0, exe_req = 1'b0;
    logic [AW-1:0] host_addr = '0, exe_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack, exe_ack, ram_cs, ram_oe, ram_we, busy;
    logic [DW-1:0] host_rdata, exe_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    int            passed = 0;
    int            total = 0;

    always #5 clk = ~clk;

    ram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .host_ld(host_ld), .host_addr(host_addr), .host_req(host_req), .host_we(host_we),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .exe_ld(exe_ld), .exe_addr(exe_addr), .exe_req(exe_req), .exe_ack(exe_ack), .exe_rdata(exe_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .busy(busy)
    );

    // RAM: 256 bytes aliased on the low address byte, preset to data = address
    logic [DW-1:0] mem [256];
    assign ram_rdata = ram_oe ? mem[ram_addr[7:0]] : 8'hEE;
    always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;

    // Reference model: an access occupies RW+3 cycles counted from the grant edge
    int            t = 0;
    bit            started = 1'b0;
    logic [DW-1:0] m_mem [256];
    logic [AW-1:0] m_hptr = '0, m_eptr = '0, m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_hrd = '0, m_erd = '0;
    logic          m_hack = 1'b0, m_eack = 1'b0, m_cs = 1'b0, m_oe = 1'b0, m_we = 1'b0;
    logic          m_own = 1'b0, m_wr = 1'b0, m_last = 1'b0;

    initial for (int i = 0; i < 256; i++) begin
        mem[i] = 8'(i);
        m_mem[i] = 8'(i);
    end

    always @(posedge clk) begin
        logic w;
        if (m_we) m_mem[m_addr[7:0]] = m_wdata;
        m_hack = 1'b0;
        m_eack = 1'b0;
        if (reset) begin
            t = 0; m_hptr = '0; m_eptr = '0; m_addr = '0; m_wdata = '0;
            m_hrd = '0; m_erd = '0; m_own = 1'b0; m_wr = 1'b0; m_last = 1'b0;
            started = 1'b1;
        end else begin
            if (t == 0) begin
                if (host_req || exe_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    w = (host_req && exe_req) ? !m_last : exe_req;
`else
                    w = exe_req;
`endif
                    m_own = w;
                    m_last = w;
                    m_wr = !w && host_we;
                    if (m_wr) m_wdata = host_wdata;
                    t = 1;
                end
            end else if (t == 1) begin
                m_addr = m_own ? m_eptr : m_hptr;
                t = 2;
            end else if (t <= RW + 1) begin
                if (t == RW + 1 && !m_wr) begin
                    if (m_own) m_erd = m_mem[m_addr[7:0]];
                    else m_hrd = m_mem[m_addr[7:0]];
                end
                t++;
            end else begin
                if (m_own) begin m_eack = 1'b1; m_eptr = m_eptr + 1; end
                else begin m_hack = 1'b1; m_hptr = m_hptr + 1; end
                t = 0;
            end
            if (host_ld) m_hptr = host_addr;
            if (exe_ld) m_eptr = exe_addr;
        end
        m_cs = (t != 0);
        m_oe = (t >= 2) && (t <= RW + 1) && !m_wr;
        m_we = (t >= 2) && (t <= RW + 1) && m_wr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else if (total - passed <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: no ack within cycle budget", name);
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) if (started) begin
        check("cs", 32'(ram_cs), 32'(m_cs));
        check("oe", 32'(ram_oe), 32'(m_oe));
        check("we", 32'(ram_we), 32'(m_we));
        check("busy", 32'(busy), 32'(m_cs));
        check("host_ack", 32'(host_ack), 32'(m_hack));
        check("exe_ack", 32'(exe_ack), 32'(m_eack));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        check("host_rdata", 32'(host_rdata), 32'(m_hrd));
        check("exe_rdata", 32'(exe_rdata), 32'(m_erd));
    end

    task automatic ld(input bit exe, input logic [AW-1:0] a);
        if (exe) begin exe_ld = 1'b1; exe_addr = a; end
        else begin host_ld = 1'b1; host_addr = a; end
        @(negedge clk);
        exe_ld = 1'b0;
        host_ld = 1'b0;
    endtask

    // One access; lat = edges from the grant edge to the edge that raises ack
    task automatic access(input bit exe, input bit we, input logic [DW-1:0] wd,
                          output int lat, output logic [AW-1:0] a, output int strobes);
        int n = 0;
        bit got = 1'b0;
        strobes = 0;
        a = '0;
        if (exe) exe_req = 1'b1;
        else begin host_req = 1'b1; host_we = we; host_wdata = wd; end
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ram_oe || ram_we) begin a = ram_addr; strobes++; end
            if (exe ? exe_ack : host_ack) got = 1'b1;
        end
        exe_req = 1'b0;
        host_req = 1'b0;
        if (!got) timeout("access");
        lat = n - 1;
    endtask

    initial begin
        int n, k, lat, s, prev;
        bit done_ld;
        logic [AW-1:0] a, a0, r;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        logic [3:0] tie_exp = 4'b0101;
        logic [AW-1:0] host_after_tie = 24'h000002;
`else
        logic [3:0] tie_exp = 4'b1111;
        logic [AW-1:0] host_after_tie = 24'h000000;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs", 32'(ram_cs), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_acks", 32'({host_ack, exe_ack}), 0);
        reset = 1'b0;

        // Host write of A5h at 80h
        ld(0, 24'h000080);
        access(0, 1, 8'hA5, lat, a, s);
        check("wr_addr", 32'(a), 32'h80);
        check("wr_strobes", 32'(s), 2);
        check("wr_latency", 32'(lat), 4);
        check("wr_model_ptr", 32'(m_hptr), 32'h81);
        check("wr_ram", 32'(mem[8'h80]), 32'hA5);

        // Host read back
        ld(0, 24'h000080);
        access(0, 0, 8'h00, lat, a, s);
        check("rd_addr", 32'(a), 32'h80);
        check("rd_data", 32'(host_rdata), 32'hA5);

        // Executor burst of three reads from 1000h
        ld(1, 24'h001000);
        exe_req = 1'b1; k = 0; n = 0; prev = 0;
        while (k < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (ram_oe) a = ram_addr;
            if (exe_ack) begin
                check($sformatf("burst_addr%0d", k), 32'(a), 32'h1000 + 32'(k));
                check($sformatf("burst_data%0d", k), 32'(exe_rdata), 32'(k));
                if (k > 0) check("burst_gap", 32'(n - prev), 5);
                prev = n;
                k++;
                if (k == 3) exe_req = 1'b0;
            end
        end
        if (k < 3) timeout("burst");

        // Pointer wrap
        ld(1, 24'hFFFFFF);
        access(1, 0, 8'h00, lat, a, s);
        check("wrap_addr", 32'(a), 32'hFFFFFF);
        check("wrap_model_ptr", 32'(m_eptr), 0);
        access(1, 0, 8'h00, lat, a, s);
        check("wrap_next", 32'(a), 0);

        // Reset during the first strobe cycle
        exe_req = 1'b1; n = 0;
        while (!ram_oe && n < 20) begin @(negedge clk); n++; end
        if (!ram_oe) timeout("midop_strobe");
        reset = 1'b1;
        exe_req = 1'b0;
        @(negedge clk);
        check("midop_strobes", 32'({ram_cs, ram_oe, ram_we}), 0);
        check("midop_busy", 32'(busy), 0);
        check("midop_ack", 32'(exe_ack), 0);
        @(negedge clk);
        check("midop_ack2", 32'(exe_ack), 0);
        reset = 1'b0;

        // Tie with both requests held, starting from reset
        host_we = 1'b0; host_req = 1'b1; exe_req = 1'b1; k = 0; n = 0; a0 = 24'hABCDEF;
        while (k < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (ram_oe && k == 0) a0 = ram_addr;
            if (host_ack || exe_ack) begin
                check($sformatf("tie_owner%0d", k), 32'(exe_ack), 32'(tie_exp[k]));
                k++;
                if (k == 4) begin host_req = 1'b0; exe_req = 1'b0; end
            end
        end
        if (k < 4) timeout("tie");
        check("tie_first_addr", 32'(a0), 0);
        access(0, 0, 8'h00, lat, a, s);
        check("tie_host_addr", 32'(a), 32'(host_after_tie));

        // Preload colliding with the post-increment in HOLD
        ld(1, 24'h000100);
        exe_req = 1'b1; k = 0; n = 0; done_ld = 1'b0; prev = 0;
        while (k < 2 && n < 60) begin
            @(negedge clk);
            n++;
            exe_ld = 1'b0;
            if (ram_oe) begin a = ram_addr; prev = 1; end
            if (prev == 1 && ram_cs && !ram_oe && !done_ld) begin
                exe_ld = 1'b1; exe_addr = 24'h000200; done_ld = 1'b1;
            end
            if (exe_ack) begin
                check($sformatf("ldcol_addr%0d", k), 32'(a), k == 0 ? 32'h100 : 32'h200);
                k++;
                if (k == 2) exe_req = 1'b0;
            end
        end
        exe_ld = 1'b0;
        if (k < 2) timeout("ldcol");
        check("ldcol_model_ptr", 32'(m_eptr), 32'h201);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            host_req = ($urandom_range(0, 2) != 0);
            exe_req = ($urandom_range(0, 2) == 0);
            host_we = $urandom_range(0, 1) == 1;
            host_wdata = 8'($urandom);
            r = 24'($urandom);
            host_ld = ($urandom_range(0, 15) == 0);
            host_addr = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'(r[1:0]) : r;
            r = 24'($urandom);
            exe_ld = ($urandom_range(0, 15) == 0);
            exe_addr = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'(r[1:0]) : r;
        end
        @(negedge clk);
        reset = 1'b0; host_req = 1'b0; exe_req = 1'b0; host_ld = 1'b0; exe_ld = 1'b0;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
